// File: rtl/ip_loopback_param_if.sv
// Stream handshake bundle between an upstream FIFO, the loopback buffer and a downstream FIFO.
// The slave modport is the buffer's view; the master modport is the FIFO side.
interface ip_loopback_param_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] in_V_V_dout;
  logic              in_V_V_empty_n;
  logic              in_V_V_read;
  logic [DATA_W-1:0] out_V_V_din;
  logic              out_V_V_full_n;
  logic              out_V_V_write;

  modport master (
    output in_V_V_dout, in_V_V_empty_n, out_V_V_full_n,
    input  in_V_V_read, out_V_V_din, out_V_V_write
  );

  modport slave (
    input  in_V_V_dout, in_V_V_empty_n, out_V_V_full_n,
    output in_V_V_read, out_V_V_din, out_V_V_write
  );
endinterface

// File: rtl/ip_loopback_param.sv
// FIFO-to-FIFO loopback through a DEPTH-entry circular buffer with an optional output transform.
// Define IP_LOOPBACK_STATS_EN to add the beat_count / stall_flag statistics ports.
module ip_loopback_param #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  ip_loopback_param_if.slave  s
`ifdef IP_LOOPBACK_STATS_EN
  ,
  output logic [31:0]         beat_count,
  output logic                stall_flag
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ;
  logic              push, pop;
  logic [DATA_W-1:0] head, xf;

  // Both strobes are forced low during reset so no pop is lost to a cleared buffer.
  assign push = s.in_V_V_empty_n && (occ < DEPTH_C) && !ap_rst;
  assign pop  = (occ != '0) && s.out_V_V_full_n && !ap_rst;

  assign s.in_V_V_read   = push;
  assign s.out_V_V_write = pop;
  assign head            = mem[rd_ptr];
  assign s.out_V_V_din   = xf;

  generate
    if (MODE == 1) begin : g_inv
      assign xf = ~head;
    end else if (MODE == 2) begin : g_rev
      for (genvar k = 0; k < NB; k++) begin : g_byte
        assign xf[8*k +: 8] = head[8*(NB-1-k) +: 8];
      end
    end else begin : g_pass
      assign xf = head;
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= s.in_V_V_dout;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef IP_LOOPBACK_STATS_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      beat_count <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (pop) beat_count <= beat_count + 32'd1;
      if ((occ == DEPTH_C) && s.in_V_V_empty_n) stall_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ip_loopback_param.sv
// Randomized and directed bench for ip_loopback_param: three DUTs (MODE 0/1/2) share one stimulus
// and are checked every cycle against a queue-based model of the buffer.
module tb_ip_loopback_param;
  localparam int DW  = 128;
  localparam int DEP = 4;
  typedef logic [DW-1:0] word_t;

  logic  ap_clk = 1'b0;
  logic  ap_rst = 1'b1;
  logic  en_l = 1'b0, fn_l = 1'b0;
  word_t dout_l = '0;

  always #5 ap_clk = ~ap_clk;

  ip_loopback_param_if #(.DATA_W(DW)) b0 ();
  ip_loopback_param_if #(.DATA_W(DW)) b1 ();
  ip_loopback_param_if #(.DATA_W(DW)) b2 ();

  assign b0.in_V_V_dout = dout_l; assign b0.in_V_V_empty_n = en_l; assign b0.out_V_V_full_n = fn_l;
  assign b1.in_V_V_dout = dout_l; assign b1.in_V_V_empty_n = en_l; assign b1.out_V_V_full_n = fn_l;
  assign b2.in_V_V_dout = dout_l; assign b2.in_V_V_empty_n = en_l; assign b2.out_V_V_full_n = fn_l;

`ifdef IP_LOOPBACK_STATS_EN
  logic [31:0] bc0, bc1, bc2;
  logic        sf0, sf1, sf2;
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(0)) d0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b0), .beat_count(bc0), .stall_flag(sf0));
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(1)) d1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b1), .beat_count(bc1), .stall_flag(sf1));
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(2)) d2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b2), .beat_count(bc2), .stall_flag(sf2));
`else
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(0)) d0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b0));
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(1)) d1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b1));
  ip_loopback_param #(.DATA_W(DW), .DEPTH(DEP), .MODE(2)) d2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .s(b2));
`endif

  // Model state: src is the upstream FIFO, q the buffer contents, obs what MODE 0 delivered.
  word_t src[$], q[$], obs[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, rd_cnt = 0, first_rd = -1, first_wr = -1;
  logic [31:0] m_beats = '0;
  bit          m_stall = 1'b0;

  function automatic word_t xf(input int m, input word_t w);
    word_t r;
    if (m == 1)      r = ~w;
    else if (m == 2) r = {<<8{w}};
    else             r = w;
    return r;
  endfunction

  task automatic chk(input string nm, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Compare, then advance the model to the state after the coming rising edge.
  always @(negedge ap_clk) begin
    bit    e_rd, e_wr;
    word_t w;
    cyc++;
    e_rd = !ap_rst && en_l && (q.size() < DEP);
    e_wr = !ap_rst && fn_l && (q.size() > 0);
    chk("read_m0", word_t'(b0.in_V_V_read), word_t'(e_rd));
    chk("read_m1", word_t'(b1.in_V_V_read), word_t'(e_rd));
    chk("read_m2", word_t'(b2.in_V_V_read), word_t'(e_rd));
    chk("write_m0", word_t'(b0.out_V_V_write), word_t'(e_wr));
    chk("write_m1", word_t'(b1.out_V_V_write), word_t'(e_wr));
    chk("write_m2", word_t'(b2.out_V_V_write), word_t'(e_wr));
    if (e_wr) begin
      chk("din_m0", b0.out_V_V_din, xf(0, q[0]));
      chk("din_m1", b1.out_V_V_din, xf(1, q[0]));
      chk("din_m2", b2.out_V_V_din, xf(2, q[0]));
    end
`ifdef IP_LOOPBACK_STATS_EN
    chk("beat_count", word_t'(bc0), word_t'(m_beats));
    chk("stall_flag", word_t'(sf0), word_t'(m_stall));
`endif
    if (b0.out_V_V_write) begin
      obs.push_back(b0.out_V_V_din);
      if (first_wr < 0) first_wr = cyc;
    end
    if (b0.in_V_V_read) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (ap_rst) begin
      q.delete();
      m_beats = '0;
      m_stall = 1'b0;
    end else begin
      if (en_l && q.size() == DEP) m_stall = 1'b1;
      if (e_wr) begin
        void'(q.pop_front());
        m_beats = m_beats + 32'd1;
      end
      if (e_rd) begin
        w = src.pop_front();
        q.push_back(w);
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit f, input int n);
    repeat (n) begin
      ap_rst = r;
      fn_l   = f;
      en_l   = e && (src.size() > 0);
      dout_l = en_l ? src[0] : word_t'({$urandom, $urandom, $urandom, $urandom});
      @(posedge ap_clk);
      #1;
    end
  endtask

  function automatic word_t rnd_word();
    return word_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    word_t a, b;
    step(1, 1, 1, 3);

    // Ordered stream of 16 words with the consumer always ready.
    obs.delete(); rd_cnt = 0; first_rd = -1; first_wr = -1;
    for (int i = 1; i <= 16; i++) src.push_back(word_t'(i));
    step(0, 1, 1, 22);
    chk("seq_count", word_t'(obs.size()), word_t'(16));
    for (int i = 0; i < 16 && i < obs.size(); i++) chk("seq_word", obs[i], word_t'(i + 1));
    chk("seq_latency", word_t'(first_wr - first_rd), word_t'(1));

    // Downstream blocked: exactly DEPTH pops, then backpressure, then in-order drain.
    obs.delete(); rd_cnt = 0;
    for (int i = 0; i < 10; i++) src.push_back(word_t'(100 + i));
    step(0, 1, 0, 10);
    chk("bp_reads", word_t'(rd_cnt), word_t'(4));
    chk("bp_read_low", word_t'(b0.in_V_V_read), word_t'(0));
`ifdef IP_LOOPBACK_STATS_EN
    chk("bp_stall", word_t'(sf0), word_t'(1));
`endif
    step(0, 1, 1, 16);
    chk("bp_drain_count", word_t'(obs.size()), word_t'(10));
    for (int i = 0; i < 10 && i < obs.size(); i++) chk("bp_drain_word", obs[i], word_t'(100 + i));

    // Transforms on hand-computed words.
    step(1, 0, 0, 1);
    a = {8{16'h00FF}};
    b = 128'h0011223344556677_8899AABBCCDDEEFF;
    src.push_back(a); src.push_back(b);
    step(0, 1, 0, 2);
    step(0, 0, 0, 1);
    chk("xf_pass_a", b0.out_V_V_din, 128'h00FF00FF00FF00FF_00FF00FF00FF00FF);
    chk("xf_inv_a", b1.out_V_V_din, 128'hFF00FF00FF00FF00_FF00FF00FF00FF00);
    chk("xf_rev_a", b2.out_V_V_din, 128'hFF00FF00FF00FF00_FF00FF00FF00FF00);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("xf_inv_b", b1.out_V_V_din, 128'hFFEEDDCCBBAA9988_7766554433221100);
    chk("xf_rev_b", b2.out_V_V_din, 128'hFFEEDDCCBBAA9988_7766554433221100);
    step(0, 0, 1, 2);

    // Mid-stream reset with three buffered words: they must vanish, later words survive.
    step(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) src.push_back(word_t'(200 + i));
    step(0, 1, 0, 3);
    step(1, 1, 1, 1);
    obs.delete();
    ap_rst = 1'b0; en_l = 1'b0; fn_l = 1'b1;
    #1;
    chk("rst_no_write", word_t'(b0.out_V_V_write), word_t'(0));
    step(0, 1, 1, 10);
    chk("rst_count", word_t'(obs.size()), word_t'(3));
    if (obs.size() > 0) chk("rst_first", obs[0], word_t'(203));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      while (src.size() < 8) src.push_back(rnd_word());
      step(($urandom % 97) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0, 1);
    end

`ifdef IP_LOOPBACK_STATS_EN
    step(0, 0, 0, 1);
    force d0.beat_count = 32'hFFFF_FFFF;
    #1;
    release d0.beat_count;
    m_beats = 32'hFFFF_FFFF;
    src.delete();
    src.push_back(rnd_word());
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    chk("beat_wrap", word_t'(bc0), word_t'(0));
`endif

    step(0, 0, 1, 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
